// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the RAM data port
// Grants one request at a time, range-checks it and runs a single RAM access.
module mem_port_arbiter #(
  parameter int ALEN   = 64,
  parameter int DLEN   = 64,
  parameter int SIZE   = 1024,
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_req,
  input  logic            r0_we,
  input  logic [ALEN-1:0] r0_addr,
  input  logic [1:0]      r0_len,
  input  logic [DLEN-1:0] r0_wdata,
  output logic            r0_ack,
  output logic            r0_err,
  output logic [DLEN-1:0] r0_rdata,
  input  logic            r1_req,
  input  logic            r1_we,
  input  logic [ALEN-1:0] r1_addr,
  input  logic [1:0]      r1_len,
  input  logic [DLEN-1:0] r1_wdata,
  output logic            r1_ack,
  output logic            r1_err,
  output logic [DLEN-1:0] r1_rdata,
  output logic [ALEN-1:0] ram_addr,
  output logic [DLEN-1:0] ram_in,
  output logic [1:0]      ram_len,
  output logic            ram_we,
  output logic            ram_re,
  input  logic [DLEN-1:0] ram_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(RD_LAT - 1);
  localparam logic [AW:0] MAX_IDX = (AW+1)'(SIZE - 1);

  state_t state, state_nx;
  logic last_grant, cur_grant, cur_we, cur_err;
  logic [CW-1:0] cnt;

  logic            req_any, both, pick, sel_we, range_err;
  logic [ALEN-1:0] sel_addr;
  logic [1:0]      sel_len;
  logic [DLEN-1:0] sel_wdata;
  logic [AW:0]     nbytes, end_idx;

  // On a tie the requester that did not win the previous tie gets the port.
  always_comb begin
    req_any   = r0_req | r1_req;
    both      = r0_req & r1_req;
    pick      = both ? ~last_grant : r1_req;
    sel_we    = pick ? r1_we    : r0_we;
    sel_addr  = pick ? r1_addr  : r0_addr;
    sel_len   = pick ? r1_len   : r0_len;
    sel_wdata = pick ? r1_wdata : r0_wdata;
    nbytes    = (AW+1)'(1) << sel_len;
    end_idx   = {1'b0, sel_addr[AW-1:0]} + nbytes - (AW+1)'(1);
    range_err = (sel_addr[ALEN-1:AW] != '0) || (end_idx > MAX_IDX);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_any) state_nx = range_err ? RESP : ACCESS;
      ACCESS:  if (cur_we || cnt == LAST) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ram_we = (state == ACCESS) &&  cur_we;
    ram_re = (state == ACCESS) && !cur_we;
    r0_ack = (state == RESP) && !cur_grant;
    r1_ack = (state == RESP) &&  cur_grant;
    r0_err = r0_ack && cur_err;
    r1_err = r1_ack && cur_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_grant  <= 1'b0;
      cur_we     <= 1'b0;
      cur_err    <= 1'b0;
      cnt        <= '0;
      ram_addr   <= '0;
      ram_in     <= '0;
      ram_len    <= '0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_any) begin
        cur_grant <= pick;
        cur_we    <= sel_we;
        cur_err   <= range_err;
        cnt       <= '0;
        if (both) last_grant <= pick;
        // Rejected requests never reach the RAM, so the RAM-side bus keeps its old value.
        if (!range_err) begin
          ram_addr <= sel_addr;
          ram_in   <= sel_wdata;
          ram_len  <= sel_len;
        end else if (!sel_we) begin
          if (pick) r1_rdata <= '0;
          else      r0_rdata <= '0;
        end
      end
      if (state == ACCESS && !cur_we) begin
        if (cnt == LAST) begin
          if (cur_grant) r1_rdata <= ram_out;
          else           r0_rdata <= ram_out;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
